// File: rtl/down_timer16.sv
// Loadable down-counter with IDLE/RUN/DONE control, auto-reload or one-shot expiry.
// Q/busy/flag update one clock after inputs; TC and CEO are combinational from Q, ce and state.
module down_timer16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             busy,
  output logic             flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] start_val;
  logic             expire;

  assign TC   = (Q == '0);
  assign busy = (state == RUN);
  assign CEO  = ce & TC & busy;

  // A same-cycle load bypasses RL so start/restart sees the fresh value.
  assign start_val = ld ? din : rl;
  // Stop and start outrank counting, so a masked tick is not an expiry.
  assign expire    = CEO & ~stop & ~start;

  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
      Q     <= '0;
      rl    <= '0;
      flag  <= 1'b0;
    end else begin
      if (ld)
        rl <= din;

      if (expire)
        flag <= 1'b1;
      else if (ack)
        flag <= 1'b0;

      case (state)
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            Q <= start_val;
          end else if (ce) begin
            if (Q != '0)
              Q <= Q - 1'b1;
            else if (periodic)
              Q <= rl;
            else
              state <= DONE;
          end
        end
        default: begin
          if (start) begin
            state <= RUN;
            Q     <= start_val;
          end else if (ld) begin
            Q <= din;
          end
        end
      endcase
    end
  end

endmodule
